// File: rtl/adc_spi_sampler.sv
// SPI front end for an external 12-bit ADC: frames a conversion every SAMPLE_GAP idle
// cycles and box-car averages 2^AVG_LOG2 samples into adc_data.
//
// state    | meaning
// IDLE     | cs_n/sclk high, gap counter runs while enable is high
// CS_SETUP | cs_n low, sclk high for CLK_DIV cycles
// SHIFT    | 32 sclk half-periods, data captured on each rising sclk
// DONE     | one cycle, frame closed, sample accumulated
module adc_spi_sampler #(
    parameter int CLK_DIV    = 25,
    parameter int SAMPLE_GAP = 1000,
    parameter int AVG_LOG2   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        adc_sdata,
    output logic        adc_cs_n,
    output logic        adc_sclk,
    output logic [11:0] adc_data,
    output logic        adc_valid
);

    localparam int GAP_W  = $clog2(SAMPLE_GAP + 1);
    localparam int DIV_W  = $clog2(CLK_DIV + 1);
    localparam int ACC_W  = 12 + AVG_LOG2;
    localparam int FCNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

    localparam logic [GAP_W-1:0]  GAP_LAST   = GAP_W'(SAMPLE_GAP - 1);
    localparam logic [DIV_W-1:0]  DIV_LOAD   = DIV_W'(CLK_DIV - 1);
    localparam logic [FCNT_W-1:0] FRAME_LAST = FCNT_W'((1 << AVG_LOG2) - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CS_SETUP = 2'd1,
        SHIFT    = 2'd2,
        DONE     = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [GAP_W-1:0]    r_gap_cnt;
    logic [DIV_W-1:0]    r_div_cnt;
    logic [4:0]          r_half_cnt;
    logic [15:0]         r_shift;
    logic [ACC_W-1:0]    r_acc;
    logic [FCNT_W-1:0]   r_frame_cnt;
    logic                r_cs_n;
    logic                r_sclk;
    logic [11:0]         r_data;
    logic                r_valid;

    logic                w_cs_n_next;
    logic                w_sclk_next;
    logic                w_div_tc;
    logic                w_shift_en;
    logic [ACC_W-1:0]    w_sum;
    logic                w_unused_hdr;

    assign w_div_tc     = (r_div_cnt == '0);
    assign w_shift_en   = (r_state == SHIFT) && w_div_tc && !r_sclk;
    assign w_sum        = r_acc + ACC_W'(r_shift[11:0]);
    // Leading four bits of each frame carry no sample data.
    assign w_unused_hdr = ^r_shift[15:12];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cs_n_next  = 1'b1;
        w_sclk_next  = 1'b1;
        case (r_state)
            IDLE: begin
                if (enable && (r_gap_cnt == GAP_LAST)) begin
                    w_state_next = CS_SETUP;
                    w_cs_n_next  = 1'b0;
                end
            end
            CS_SETUP: begin
                w_cs_n_next = 1'b0;
                if (w_div_tc) begin
                    w_state_next = SHIFT;
                    w_sclk_next  = 1'b0;
                end
            end
            SHIFT: begin
                w_cs_n_next = 1'b0;
                w_sclk_next = r_sclk;
                if (w_div_tc) begin
                    // Half 31 ends with sclk already high, so closing the frame leaves it idle-high.
                    if (r_half_cnt == 5'd31) begin
                        w_state_next = DONE;
                        w_cs_n_next  = 1'b1;
                        w_sclk_next  = 1'b1;
                    end else begin
                        w_sclk_next = ~r_sclk;
                    end
                end
            end
            DONE: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_gap_cnt   <= '0;
            r_div_cnt   <= DIV_LOAD;
            r_half_cnt  <= '0;
            r_shift     <= '0;
            r_acc       <= '0;
            r_frame_cnt <= '0;
            r_cs_n      <= 1'b1;
            r_sclk      <= 1'b1;
            r_data      <= '0;
            r_valid     <= 1'b0;
        end else begin
            r_cs_n  <= w_cs_n_next;
            r_sclk  <= w_sclk_next;
            r_valid <= 1'b0;

            if (r_state == IDLE) begin
                if (!enable || (r_gap_cnt == GAP_LAST)) begin
                    r_gap_cnt <= '0;
                end else begin
                    r_gap_cnt <= r_gap_cnt + GAP_W'(1);
                end
            end

            if ((r_state == IDLE) || (r_state == DONE) || w_div_tc) begin
                r_div_cnt <= DIV_LOAD;
            end else begin
                r_div_cnt <= r_div_cnt - DIV_W'(1);
            end

            if (r_state != SHIFT) begin
                r_half_cnt <= '0;
            end else if (w_div_tc) begin
                r_half_cnt <= r_half_cnt + 5'd1;
            end

            if (w_shift_en) begin
                r_shift <= {r_shift[14:0], adc_sdata};
            end

            if (r_state == DONE) begin
                if (r_frame_cnt == FRAME_LAST) begin
                    r_data      <= 12'(w_sum >> AVG_LOG2);
                    r_valid     <= 1'b1;
                    r_acc       <= '0;
                    r_frame_cnt <= '0;
                end else begin
                    r_acc       <= w_sum;
                    r_frame_cnt <= r_frame_cnt + FCNT_W'(1);
                end
            end
        end
    end

    assign adc_cs_n  = r_cs_n;
    assign adc_sclk  = r_sclk;
    assign adc_data  = r_data;
    assign adc_valid = r_valid;

endmodule

// File: doc/adc_spi_sampler.md
ADC_SPI_SAMPLER -- requirements
Module: adc_spi_sampler

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; all state SHALL change only on the rising clk edge.
REQ-002 Parameter CLK_DIV, default 25, SHALL set the SCLK half-period in clk cycles (minimum 2).
REQ-003 Parameter SAMPLE_GAP, default 1000, SHALL set the idle clk cycles between conversion frames (minimum 1).
REQ-004 Parameter AVG_LOG2, default 2, SHALL set the averaging depth to 2^AVG_LOG2 frames (range 0..4).
REQ-005 Port clk, input, 1 bit, SHALL be the system clock.
REQ-006 Port rst, input, 1 bit, SHALL be the synchronous active-high reset.
REQ-007 Port enable, input, 1 bit, SHALL permit new conversion frames when high.
REQ-008 Port adc_sdata, input, 1 bit, SHALL be the serial data from the external 12-bit ADC.
REQ-009 Port adc_cs_n, output, 1 bit, SHALL be the active-low ADC chip select.
REQ-010 Port adc_sclk, output, 1 bit, SHALL be the ADC serial clock, idling high.
REQ-011 Port adc_data, output, 12 bits, SHALL carry the averaged sample (0-4095) consumed by the freq_code converter.
REQ-012 Port adc_valid, output, 1 bit, SHALL pulse for one clk cycle when adc_data updates.

Function
REQ-013 The FSM SHALL have states IDLE, CS_SETUP, SHIFT and DONE.
REQ-014 In IDLE: adc_cs_n=1 and adc_sclk=1; the gap counter increments while enable=1 and is held at 0 while enable=0.
REQ-015 In IDLE: when the gap counter equals SAMPLE_GAP-1 with enable=1, the FSM moves to CS_SETUP and clears the gap counter.
REQ-016 In CS_SETUP: adc_cs_n=0 and adc_sclk=1 for CLK_DIV cycles, then the FSM moves to SHIFT with adc_sclk driven low.
REQ-017 In SHIFT: adc_sclk toggles every CLK_DIV cycles, giving 16 full periods (32 half-periods).
REQ-018 On each cycle where registered adc_sclk goes 0->1, adc_sdata SHALL be shifted MSB-first into a 16-bit register.
REQ-019 After the 16th rising half-period completes, the FSM moves to DONE.
REQ-020 Of each frame, bits [15:12] SHALL be ignored and bits [11:0] SHALL be the sample.
REQ-021 DONE SHALL last one cycle with adc_cs_n=1 and adc_sclk=1, then return to IDLE.
REQ-022 In DONE, the sample SHALL be added to an accumulator of width 12+AVG_LOG2, with no overflow possible.
REQ-023 In DONE, the frame counter SHALL increment.
REQ-024 When the frame counter reaches 2^AVG_LOG2-1 in DONE: adc_data <= (accumulator+sample) >> AVG_LOG2 (floor), adc_valid=1 in the following cycle, and both accumulator and frame counter clear.
REQ-025 Frame length SHALL be exactly CLK_DIV + 32*CLK_DIV + 1 clk cycles from CS_SETUP entry to IDLE re-entry.
REQ-026 Deasserting enable mid-frame SHALL NOT abort the frame; the frame completes and the FSM then holds in IDLE.
REQ-027 Partial averages SHALL be retained across enable low periods.
REQ-028 adc_data SHALL hold its last value between updates.
REQ-029 adc_valid SHALL never be high for two consecutive cycles.

Reset
REQ-030 While rst=1 at a clk edge, all state SHALL be forced to reset values: state=IDLE, adc_cs_n=1, adc_sclk=1, adc_data=0, adc_valid=0, and shift register, accumulator, gap counter and frame counter all 0.
REQ-031 Reset asserted mid-frame SHALL abort the frame: adc_cs_n returns to 1 on the next edge and no adc_valid is produced.
REQ-032 After rst deasserts, the first frame SHALL start SAMPLE_GAP cycles later if enable=1.

Verification
REQ-033 Reset check: rst high 3 cycles -> adc_cs_n=1, adc_sclk=1, adc_data=0x000, adc_valid=0.
REQ-034 Single frame: AVG_LOG2=0, ADC model returns 0xABC with leading bits 1111 -> adc_data=0xABC, one adc_valid pulse, adc_cs_n low for 33*CLK_DIV cycles.
REQ-035 Full-scale average: AVG_LOG2=2, four frames of 4095 -> adc_data=4095, no wrap.
REQ-036 Floor average: AVG_LOG2=2, frames 0,1,2,3 -> adc_data=1, adc_valid asserted only after the 4th frame.
REQ-037 Enable drop: enable=0 during SHIFT -> frame completes, no further adc_cs_n falling edge until enable=1.
REQ-038 Reset mid-frame: rst during SHIFT bit 7 -> adc_cs_n=1 next cycle, no adc_valid, adc_data=0, and the next average starts fresh.
